eth_tx_arbiter: RTL

- Packet-granular arbiter sharing the single 8-bit AXI-Stream MAC transmit path between the ARP reply generator and the IP/UDP transmit path.
- It is the transmit-side counterpart of the receive demux.
- Locks the grant for a whole frame, enforces an inter-frame gap, and aborts frames whose source stalls mid-packet.

---
 rtl/eth_tx_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// Shares the 8-bit AXI-Stream MAC transmit path between the ARP reply generator and the IP/UDP path.
// The grant is held for a whole frame, an inter-frame gap follows, and stalled frames are aborted then flushed.
module eth_tx_arbiter #(
  parameter int ARP_PRIORITY  = 1,
  parameter int IFG_CYCLES    = 12,
  parameter int TIMEOUT_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  arp_axis_tdata_in,
  input  logic        arp_axis_tvalid_in,
  input  logic        arp_axis_tlast_in,
  output logic        arp_axis_tready_o,
  input  logic [7:0]  ip_axis_tdata_in,
  input  logic        ip_axis_tvalid_in,
  input  logic        ip_axis_tlast_in,
  output logic        ip_axis_tready_o,
  output logic [7:0]  mac_axis_tdata_out,
  output logic        mac_axis_tvalid_out,
  output logic        mac_axis_tlast_out,
  output logic        mac_axis_tuser_out,
  input  logic        mac_axis_tready_in,
  output logic        busy_o,
  output logic [15:0] arp_frames_o,
  output logic [15:0] ip_frames_o,
  output logic [7:0]  abort_cnt_o
);

  localparam int GAP_W    = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
  localparam int GAP_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, ARP_TX, IP_TX, ABORT, FLUSH, GAP} state_t;

  localparam state_t FRAME_END = (IFG_CYCLES > 0) ? GAP : IDLE;

  state_t                   state, state_d;
  logic                     last_arp, last_arp_d;
  logic [TIMEOUT_WIDTH-1:0] wd, wd_d;
  logic [GAP_W-1:0]         gap_cnt, gap_cnt_d;
  logic                     arp_done, ip_done, abort_done;
  logic                     src_valid, src_last;
  logic [7:0]               src_data;

  // last_arp doubles as the current grant once a TX/ABORT/FLUSH state is entered
  assign src_valid = last_arp ? arp_axis_tvalid_in : ip_axis_tvalid_in;
  assign src_last  = last_arp ? arp_axis_tlast_in  : ip_axis_tlast_in;
  assign src_data  = last_arp ? arp_axis_tdata_in  : ip_axis_tdata_in;
  assign busy_o    = (state != IDLE);

  always_comb begin
    state_d             = state;
    last_arp_d          = last_arp;
    wd_d                = wd;
    gap_cnt_d           = gap_cnt;
    arp_done            = 1'b0;
    ip_done             = 1'b0;
    abort_done          = 1'b0;
    arp_axis_tready_o   = 1'b0;
    ip_axis_tready_o    = 1'b0;
    mac_axis_tdata_out  = '0;
    mac_axis_tvalid_out = 1'b0;
    mac_axis_tlast_out  = 1'b0;
    mac_axis_tuser_out  = 1'b0;
    unique case (state)
      IDLE: begin
        wd_d = '0;
        if (arp_axis_tvalid_in &&
            (!ip_axis_tvalid_in || (ARP_PRIORITY != 0) || !last_arp)) begin
          state_d    = ARP_TX;
          last_arp_d = 1'b1;
        end else if (ip_axis_tvalid_in) begin
          state_d    = IP_TX;
          last_arp_d = 1'b0;
        end
      end
      ARP_TX, IP_TX: begin
        mac_axis_tdata_out  = src_data;
        mac_axis_tvalid_out = src_valid;
        mac_axis_tlast_out  = src_last;
        arp_axis_tready_o   = last_arp && mac_axis_tready_in;
        ip_axis_tready_o    = !last_arp && mac_axis_tready_in;
        if (src_valid && mac_axis_tready_in) begin
          wd_d = '0;
          if (src_last) begin
            arp_done  = last_arp;
            ip_done   = !last_arp;
            state_d   = FRAME_END;
            gap_cnt_d = GAP_W'(GAP_LOAD);
          end
        end else begin
          // a transfer on the expiry cycle takes the branch above, so it wins
          wd_d = wd + 1'b1;
          if (&wd_d) begin
            state_d = ABORT;
            wd_d    = '0;
          end
        end
      end
      ABORT: begin
        mac_axis_tvalid_out = 1'b1;
        mac_axis_tlast_out  = 1'b1;
        mac_axis_tuser_out  = 1'b1;
        if (mac_axis_tready_in) begin
          abort_done = 1'b1;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        arp_axis_tready_o = last_arp;
        ip_axis_tready_o  = !last_arp;
        if (src_valid && src_last) begin
          state_d   = FRAME_END;
          gap_cnt_d = GAP_W'(GAP_LOAD);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_cnt_d = gap_cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_arp     <= 1'b0;
      wd           <= '0;
      gap_cnt      <= '0;
      arp_frames_o <= '0;
      ip_frames_o  <= '0;
      abort_cnt_o  <= '0;
    end else begin
      state    <= state_d;
      last_arp <= last_arp_d;
      wd       <= wd_d;
      gap_cnt  <= gap_cnt_d;
      if (arp_done) arp_frames_o <= arp_frames_o + 16'd1;
      if (ip_done)  ip_frames_o  <= ip_frames_o + 16'd1;
      if (abort_done && (abort_cnt_o != 8'hFF)) abort_cnt_o <= abort_cnt_o + 8'd1;
    end
  end

endmodule
